// File: rtl/sensor_frame_aligner.sv
// Ingress aligner: packs three 16-bit sensor word streams into 256-bit vectors and
// presents them together as one frame, force-closing stalled lanes after a timeout.
module sensor_frame_aligner #(
  parameter int unsigned WORD_WIDTH      = 16,
  parameter int unsigned WORDS_PER_FRAME = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [3*WORD_WIDTH-1:0]               s_data,
  input  logic [2:0]                            s_valid,
  input  logic [2:0]                            s_last,
  output logic [2:0]                            s_ready,
  output logic [WORD_WIDTH*WORDS_PER_FRAME-1:0] out_sensor1_raw,
  output logic [WORD_WIDTH*WORDS_PER_FRAME-1:0] out_sensor2_raw,
  output logic [WORD_WIDTH*WORDS_PER_FRAME-1:0] out_sensor3_raw,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [2:0]                            out_missing,
  output logic [2:0]                            out_len_err,
  output logic [CNT_W-1:0]                      frame_count
);

  localparam int unsigned LANES = 3;
  localparam int unsigned IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  state_t state, state_next;

  logic [LANES-1:0][WORDS_PER_FRAME-1:0][WORD_WIDTH-1:0] vec_q, vec_d;
  logic [LANES-1:0][IDX_W-1:0] idx_q, idx_d;
  logic [LANES-1:0]            done_q, done_d;
  logic [LANES-1:0]            miss_q, miss_d;
  logic [LANES-1:0]            lerr_q, lerr_d;
  logic                        armed_q, armed_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic [CNT_W-1:0]            cnt_d;
  logic [LANES-1:0]            ready_d;
  logic                        valid_d;

  logic [LANES-1:0] accept;
  logic             handshake;
  logic             timeout_fire;

  assign accept       = s_valid & s_ready;
  assign handshake    = out_valid & out_ready;
  // Timer only runs once a frame has started; fires while some lane is still open.
  assign timeout_fire = (state == COLLECT) && armed_q && (tmo_q == TMO_LAST) && !(&done_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if ((&done_q) || timeout_fire) state_next = PRESENT;
      PRESENT: if (handshake) state_next = COLLECT;
    endcase
  end

  always_comb begin
    vec_d   = vec_q;
    idx_d   = idx_q;
    done_d  = done_q;
    miss_d  = miss_q;
    lerr_d  = lerr_q;
    armed_d = armed_q;
    tmo_d   = tmo_q;
    cnt_d   = frame_count;
    if (state == PRESENT) begin
      if (handshake) begin
        vec_d   = '0;
        idx_d   = '0;
        done_d  = '0;
        miss_d  = '0;
        lerr_d  = '0;
        armed_d = 1'b0;
        tmo_d   = '0;
        cnt_d   = frame_count + CNT_W'(1);
      end
    end else begin
      if (armed_q) tmo_d = tmo_q + TMO_W'(1);
      if (|accept) armed_d = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        if (accept[k]) begin
          vec_d[k][idx_q[k]] = s_data[k*WORD_WIDTH +: WORD_WIDTH];
          idx_d[k]           = idx_q[k] + IDX_W'(1);
          // Length error when the marker and the word count disagree.
          if (s_last[k] || (idx_q[k] == LAST_IDX)) begin
            done_d[k] = 1'b1;
            lerr_d[k] = s_last[k] != (idx_q[k] == LAST_IDX);
          end
        end
        // A lane finishing on the timeout edge counts as complete, not missing.
        if (timeout_fire && !done_d[k]) begin
          done_d[k] = 1'b1;
          miss_d[k] = 1'b1;
        end
      end
    end
    ready_d = (state_next == COLLECT) ? ~done_d : '0;
    valid_d = (state_next == PRESENT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q       <= '0;
      idx_q       <= '0;
      done_q      <= '0;
      miss_q      <= '0;
      lerr_q      <= '0;
      armed_q     <= 1'b0;
      tmo_q       <= '0;
      frame_count <= '0;
      s_ready     <= '0;
      out_valid   <= 1'b0;
    end else begin
      vec_q       <= vec_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      miss_q      <= miss_d;
      lerr_q      <= lerr_d;
      armed_q     <= armed_d;
      tmo_q       <= tmo_d;
      frame_count <= cnt_d;
      s_ready     <= ready_d;
      out_valid   <= valid_d;
    end
  end

  assign out_sensor1_raw = vec_q[0];
  assign out_sensor2_raw = vec_q[1];
  assign out_sensor3_raw = vec_q[2];
  assign out_missing     = miss_q;
  assign out_len_err     = lerr_q;

endmodule

// File: tb/tb_sensor_frame_aligner.sv
// Scoreboard bench for sensor_frame_aligner: lane drivers feed word queues, expected
// frames are queued at stimulus time and compared when out_valid rises.
module tb_sensor_frame_aligner;

  logic         clk;
  logic         rst_n;
  logic [47:0]  s_data;
  logic [2:0]   s_valid, s_last, s_ready;
  logic [255:0] r1, r2, r3;
  logic         out_valid, out_ready;
  logic [2:0]   out_missing, out_len_err;
  logic [1:0]   frame_count;

  sensor_frame_aligner #(
    .WORD_WIDTH(16), .WORDS_PER_FRAME(16), .TIMEOUT_CYCLES(32), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .out_sensor1_raw(r1), .out_sensor2_raw(r2), .out_sensor3_raw(r3),
    .out_valid(out_valid), .out_ready(out_ready), .out_missing(out_missing),
    .out_len_err(out_len_err), .frame_count(frame_count)
  );

  typedef struct packed {
    logic [2:0][255:0] raw;
    logic [2:0]        miss;
    logic [2:0]        lerr;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     build, e, obs_f;
  logic [16:0] lane_mem [3][512];
  int         head [3];
  int         tail [3];
  logic [2:0] pend;
  bit         gap_en;
  bit         first_pending;
  int         first_acc_cyc;
  int         cyc;
  int         n_cmp, n_err;
  logic [1:0] exp_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Lane driver: present queue heads at negedge, pop once the following edge took them.
  initial begin
    s_valid = '0; s_data = '0; s_last = '0; pend = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (pend[k]) head[k]++;
        if (rst_n && head[k] != tail[k] && !(gap_en && ((cyc + k) % 4 == 0))) begin
          s_valid[k]         = 1'b1;
          s_data[k*16 +: 16] = lane_mem[k][head[k] % 512][15:0];
          s_last[k]          = lane_mem[k][head[k] % 512][16];
        end else begin
          s_valid[k]         = 1'b0;
          s_data[k*16 +: 16] = '0;
          s_last[k]          = 1'b0;
        end
        pend[k] = s_valid[k] && s_ready[k];
        if (pend[k] && first_pending) begin
          first_acc_cyc = cyc + 1;
          first_pending = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic queue_lane(input int k, input int n, input bit last_at_end, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      w = base + 16'(i);
      lane_mem[k][tail[k] % 512] = {last_at_end && (i == n - 1), w};
      tail[k]++;
      build.raw[k][i*16 +: 16] = w;
    end
  endtask

  task automatic queue_full(input logic [15:0] base);
    build = '0;
    for (int k = 0; k < 3; k++) queue_lane(k, 16, 1'b1, base + 16'(k * 256));
    exp_q.push_back(build);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drained(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (head[0] == tail[0] && head[1] == tail[1] && head[2] == tail[2] && pend == 3'b000) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) head[k] = tail[k];
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; gap_en = 1'b0; first_pending = 1'b0;
    exp_cnt = '0; n_cmp = 0; n_err = 0;
    for (int k = 0; k < 3; k++) begin head[k] = 0; tail[k] = 0; end
    #3;
    obs_f = {r3, r2, r1, out_missing, out_len_err};
    n_cmp++;
    if (obs_f !== '0 || out_valid !== 1'b0 || s_ready !== 3'b000 || frame_count !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b ready=%b count=%0d frame_nonzero=%b, required 0/000/0/0",
               out_valid, s_ready, frame_count, |obs_f);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 3'b111 || out_valid !== 1'b0 || frame_count !== 2'd0) begin
      n_err++;
      $display("FAIL reset_release: ready=%b valid=%b count=%0d, required 111/0/0", s_ready, out_valid, frame_count);
    end
  endtask

  task automatic test_basic();
    bit ok;
    gap_en = 1'b1;
    queue_full(16'h0000);
    wait_valid(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL basic_valid: out_valid=0 after bound, required 1");
      return;
    end
    obs_f = {r3, r2, r1, out_missing, out_len_err};
    n_cmp++;
    if (obs_f !== e) begin
      n_err++;
      $display("FAIL basic_frame: got %h want %h", obs_f, e);
    end
    n_cmp++;
    if (frame_count !== exp_cnt) begin
      n_err++;
      $display("FAIL basic_count_before: got %0d want %0d", frame_count, exp_cnt);
    end
    handshake();
    exp_cnt++;
    n_cmp++;
    if (out_valid !== 1'b0 || frame_count !== exp_cnt) begin
      n_err++;
      $display("FAIL basic_after_hs: valid=%b count=%0d, required 0/%0d", out_valid, frame_count, exp_cnt);
    end
  endtask

  task automatic test_stall();
    bit ok;
    gap_en = 1'b0;
    queue_full(16'h1000);
    wait_valid(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL stall_valid: out_valid=0 after bound, required 1");
      return;
    end
    queue_full(16'h2000);
    for (int i = 0; i < 20; i++) begin
      obs_f = {r3, r2, r1, out_missing, out_len_err};
      n_cmp++;
      if (obs_f !== e || out_valid !== 1'b1 || s_ready !== 3'b000) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: valid=%b ready=%b frame_match=%b, required 1/000/1",
                 i, out_valid, s_ready, obs_f === e);
      end
      @(negedge clk);
    end
    handshake();
    exp_cnt++;
    n_cmp++;
    if (out_valid !== 1'b0 || s_ready !== 3'b111 || s_valid !== 3'b111 || frame_count !== exp_cnt) begin
      n_err++;
      $display("FAIL stall_release: valid=%b ready=%b svalid=%b count=%0d, required 0/111/111/%0d",
               out_valid, s_ready, s_valid, frame_count, exp_cnt);
    end
    wait_valid(ok);
    e = exp_q.pop_front();
    obs_f = {r3, r2, r1, out_missing, out_len_err};
    n_cmp++;
    if (!ok || obs_f !== e) begin
      n_err++;
      $display("FAIL stall_next_frame: valid=%b got %h want %h", ok, obs_f, e);
    end
    handshake();
    exp_cnt++;
  endtask

  task automatic test_len_err();
    bit ok;
    gap_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      build = '0;
      queue_lane(0, 16, (f == 0), 16'h4000);
      queue_lane(1, (f == 0) ? 5 : 16, 1'b1, 16'h4100);
      queue_lane(2, 16, 1'b1, 16'h4200);
      build.lerr = (f == 0) ? 3'b010 : 3'b001;
      exp_q.push_back(build);
      wait_valid(ok);
      e = exp_q.pop_front();
      obs_f = {r3, r2, r1, out_missing, out_len_err};
      n_cmp++;
      if (!ok || obs_f !== e) begin
        n_err++;
        $display("FAIL len_err_frame%0d: valid=%b got %h want %h", f, ok, obs_f, e);
      end
      handshake();
      exp_cnt++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int vcyc;
    gap_en = 1'b0;
    build = '0;
    first_pending = 1'b1;
    queue_lane(0, 16, 1'b1, 16'h6000);
    queue_lane(1, 16, 1'b1, 16'h6100);
    queue_lane(2, 3, 1'b0, 16'h6200);
    build.miss = 3'b100;
    exp_q.push_back(build);
    wait_valid(ok);
    vcyc = cyc;
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || vcyc - first_acc_cyc != 32) begin
      n_err++;
      $display("FAIL timeout_latency: valid=%b latency=%0d, required 32", ok, vcyc - first_acc_cyc);
    end
    obs_f = {r3, r2, r1, out_missing, out_len_err};
    n_cmp++;
    if (obs_f !== e) begin
      n_err++;
      $display("FAIL timeout_frame: got %h want %h", obs_f, e);
    end
    queue_full(16'h7000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || s_ready !== 3'b000) begin
        n_err++;
        $display("FAIL timeout_backpressure cycle %0d: valid=%b ready=%b, required 1/000", i, out_valid, s_ready);
      end
    end
    handshake();
    exp_cnt++;
    wait_valid(ok);
    e = exp_q.pop_front();
    obs_f = {r3, r2, r1, out_missing, out_len_err};
    n_cmp++;
    if (!ok || obs_f !== e) begin
      n_err++;
      $display("FAIL timeout_next_frame: valid=%b got %h want %h", ok, obs_f, e);
    end
    handshake();
    exp_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    gap_en = 1'b0;
    build = '0;
    for (int k = 0; k < 3; k++) queue_lane(k, 7, 1'b0, 16'h8000 + 16'(k * 256));
    wait_drained(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL reset_mid_drain: lanes not drained, required all 7 words accepted");
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) head[k] = tail[k];
    obs_f = {r3, r2, r1, out_missing, out_len_err};
    n_cmp++;
    if (obs_f !== '0 || out_valid !== 1'b0 || s_ready !== 3'b000 || frame_count !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear: valid=%b ready=%b count=%0d frame_nonzero=%b, required 0/000/0/0",
               out_valid, s_ready, frame_count, |obs_f);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    queue_full(16'h9000);
    wait_valid(ok);
    e = exp_q.pop_front();
    obs_f = {r3, r2, r1, out_missing, out_len_err};
    n_cmp++;
    if (!ok || obs_f !== e) begin
      n_err++;
      $display("FAIL reset_mid_frame: valid=%b got %h want %h", ok, obs_f, e);
    end
    handshake();
    exp_cnt++;
    n_cmp++;
    if (frame_count !== exp_cnt) begin
      n_err++;
      $display("FAIL reset_mid_count: got %0d want %0d", frame_count, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    pulse_reset();
    for (int f = 0; f < 5; f++) begin
      gap_en = f[0];
      queue_full(16'hA000 + 16'(f * 16));
      wait_valid(ok);
      e = exp_q.pop_front();
      obs_f = {r3, r2, r1, out_missing, out_len_err};
      n_cmp++;
      if (!ok || obs_f !== e) begin
        n_err++;
        $display("FAIL wrap_frame%0d: valid=%b got %h want %h", f, ok, obs_f, e);
      end
      handshake();
      exp_cnt++;
      n_cmp++;
      if (frame_count !== exp_cnt) begin
        n_err++;
        $display("FAIL wrap_count%0d: got %0d want %0d", f, frame_count, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len_err();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_frame_aligner.md
Name: sensor_frame_aligner

Overview:
- Upstream ingress stage of the fusion pipeline.
- Accepts three independent 16-bit word streams, one per sensor, each with a valid/ready handshake.
- Packs each stream into a 256-bit raw vector and presents all three together as one time-aligned frame on a valid/ready output.
- The output feeds the fusion core's sensor1_raw/sensor2_raw/sensor3_raw inputs. A stalled sensor is bounded by a timeout and flagged, never waited on forever.

Parameters:
- WORD_WIDTH, 16, width of one sensor word
- WORDS_PER_FRAME, 16, words per sensor vector (WORD_WIDTH*WORDS_PER_FRAME = 256)
- TIMEOUT_CYCLES, 1024, cycles after a frame's first accepted word before incomplete lanes are force-closed
- CNT_W, 16, width of frame_count

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  48  lane k word at bits [16k+15:16k], k = 0..2
- s_valid  in  3  per-lane word valid
- s_last  in  3  per-lane end-of-vector marker
- s_ready  out  3  per-lane ready
- out_sensor1_raw  out  256  lane 0 vector
- out_sensor2_raw  out  256  lane 1 vector
- out_sensor3_raw  out  256  lane 2 vector
- out_valid  out  1  aligned frame available
- out_ready  in  1  downstream accepts frame
- out_missing  out  3  lane closed by timeout, qualified by out_valid
- out_len_err  out  3  lane length mismatch, qualified by out_valid
- frame_count  out  CNT_W  frames delivered, wraps modulo 2^CNT_W

Behaviour:
- Reset state: all outputs 0, all buffers 0, lane counters 0, timeout counter 0, FSM = COLLECT.
  - s_ready = 3'b000 while rst_n is low.
  - s_ready = 3'b111 from the first clock after deassertion.
- A word is accepted on lane k when s_valid[k] && s_ready[k] at a rising clk edge.
- Per lane:
  - 4-bit word index w. Accepted word is written to buffer bits [16w+15:16w] (word 0 = LSBs), then w increments.
  - Lane closes (done[k] = 1) when either the WORDS_PER_FRAME-th word is accepted or a word with s_last[k] = 1 is accepted.
  - Early s_last (w+1 < 16): remaining words stay 0 and len_err[k] is set.
  - 16th word without s_last: len_err[k] is set. The lane still closes, and the next word on that lane becomes word 0 of the next frame.
  - s_ready[k] = (state == COLLECT) && !done[k].
- FSM states:
  - COLLECT → PRESENT when all three done bits are 1, evaluated on registered done after the edge. The last word is accepted at edge N and out_valid = 1 from edge N+1.
  - PRESENT:
    - out_valid = 1.
    - out_sensor*_raw, out_missing and out_len_err are held stable until out_ready = 1.
    - s_ready = 3'b000.
    - On the out_valid && out_ready edge: clear buffers, w, done, missing, len_err and the timeout counter; increment frame_count; return to COLLECT. out_valid = 0 on the following cycle.
  - out_valid never drops without a handshake.
- Timeout:
  - Counter is armed by the first word accepted on any lane in the current frame, and increments every COLLECT cycle thereafter.
  - When count == TIMEOUT_CYCLES-1 and some lane is not done:
    - Those lanes are forced done with missing[k] = 1.
    - Partially received words are retained; untouched words read 0.
    - The FSM enters PRESENT next cycle.
  - If a lane's final word is accepted on the same edge the timeout fires, completion wins for that lane and missing[k] = 0.
  - With no words accepted, the counter stays 0 and the block waits indefinitely.
- Lane words arriving after a timeout close, or during PRESENT, are back-pressured and become words of the next frame.
- Asynchronous reset mid-frame discards all partial data immediately. No frame is emitted, and frame_count returns to 0.
- frame_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Three lanes each send words 0x0k00+i (i = 0..15), s_last on i = 15, with interleaved valid gaps → one out_valid. out_sensor(k+1)_raw[16i+15:16i] = 0x0k00+i, out_missing = 0, out_len_err = 0, frame_count 0→1 after handshake.
- Complete frame with out_ready held 0 for 20 cycles → out_valid and data stable for all 20 cycles, s_ready = 0. Frame completes on the cycle out_ready rises, and the next frame's words are accepted from the following cycle.
- Lane 1 asserts s_last on word 4 (5 words), other lanes full → lane 1 vector bits [79:0] hold data and [255:80] = 0; out_len_err = 3'b010.
- TIMEOUT_CYCLES = 32; lane 2 sends only 3 words, lanes 0–1 full → out_valid exactly 32 cycles after the first accepted word, out_missing = 3'b100, lane 2 bits [255:48] = 0. Words lane 2 sends afterwards appear as word 0+ of the next frame.
- rst_n pulsed low mid-frame after 7 words on each lane → outputs 0 immediately. The next full frame is delivered clean with frame_count = 1 after handshake.
- CNT_W = 2, deliver 5 frames → frame_count sequence 1, 2, 3, 0, 1.
